// File: rtl/lsu.sv
// Load/store unit: accepts one load or store at a time, hands it to the memory controller and returns a tagged result.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses with an exception response instead of a memory request.
module lsu #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_base,
    input  logic [31:0]      req_offset,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_signed,
    output logic [31:0]      mem_addr,
    output logic [1:0]       mem_len,
    output logic [31:0]      mem_w_data,
    input  logic [31:0]      mem_r_data,
    input  logic             mem_done,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_exc
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic             ready_q;
    logic             store_q;
    logic             kill_q;
    logic             exc_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      addr;
    logic [31:0]      wdata_masked;
    logic [1:0]       len;
    logic             misaligned;
    logic             accept;

    // ready_q marks IDLE; flush only gates it so a squash blocks acceptance in the same cycle.
    assign req_ready = ready_q & ~flush;
    assign accept    = req_valid & req_ready;

    always_comb begin
        addr = req_base + req_offset;
        case (req_funct3[1:0])
            2'd0: begin
                len          = 2'd0;
                wdata_masked = {24'd0, req_wdata[7:0]};
            end
            2'd1: begin
                len          = 2'd1;
                wdata_masked = {16'd0, req_wdata[15:0]};
            end
            default: begin
                len          = 2'd3;
                wdata_masked = req_wdata;
            end
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        misaligned = ((len == 2'd1) && addr[0]) || ((len == 2'd3) && (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            store_q    <= 1'b0;
            kill_q     <= 1'b0;
            exc_q      <= 1'b0;
            tag_q      <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_signed <= 1'b0;
            mem_addr   <= 32'd0;
            mem_len    <= 2'd0;
            mem_w_data <= 32'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_tag   <= '0;
            resp_exc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ISSUE;
                        ready_q    <= 1'b0;
                        store_q    <= req_store;
                        tag_q      <= req_tag;
                        kill_q     <= 1'b0;
                        exc_q      <= misaligned;
                        mem_addr   <= addr;
                        mem_len    <= len;
                        mem_signed <= ~req_store & ~req_funct3[2];
                        mem_w_data <= wdata_masked;
                        mem_read   <= ~req_store & ~misaligned;
                        mem_write  <= req_store & ~misaligned;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (flush && !store_q) begin
                        kill_q <= 1'b1;
                    end
                    // A rejected misaligned access has no memory phase; its address becomes the payload.
                    if (exc_q) begin
                        state      <= RESP;
                        resp_valid <= store_q | ~(kill_q | flush);
                        resp_exc   <= 1'b1;
                        resp_data  <= mem_addr;
                        resp_tag   <= tag_q;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush && !store_q) begin
                        kill_q <= 1'b1;
                    end
                    // A flush arriving alongside mem_done still kills the load.
                    if (mem_done) begin
                        state      <= RESP;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        resp_valid <= store_q | ~(kill_q | flush);
                        resp_exc   <= 1'b0;
                        resp_data  <= store_q ? 32'd0 : mem_r_data;
                        resp_tag   <= tag_q;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    ready_q    <= 1'b1;
                    kill_q     <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_exc   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
Parameters:
REQ-001 The block SHALL have parameter TAG_W, default 5, giving the destination-register tag width.
Ports:
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port req_valid, input, 1, the pipeline presenting a load/store.
REQ-005 The block SHALL have port req_ready, output, 1, the LSU accepting a request this cycle.
REQ-006 The block SHALL have port req_store, input, 1, where 1 = store and 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3, the RISC-V width/sign code (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
REQ-008 The block SHALL have ports req_base and req_offset, input, 32 each, the address operands.
REQ-009 The block SHALL have port req_wdata, input, 32, the store data.
REQ-010 The block SHALL have port req_tag, input, TAG_W, the destination tag.
REQ-011 The block SHALL have port flush, input, 1, the pipeline squash.
REQ-012 The block SHALL have ports mem_read and mem_write, output, 1 each, the memory-controller requests.
REQ-013 The block SHALL have port mem_signed, output, 1, requesting sign extension.
REQ-014 The block SHALL have port mem_addr, output, 32, the byte address.
REQ-015 The block SHALL have port mem_len, output, 2, encoded 0 = byte, 1 = half, 3 = word.
REQ-016 The block SHALL have port mem_w_data, output, 32, the store data.
REQ-017 The block SHALL have port mem_r_data, input, 32, the extended load data.
REQ-018 The block SHALL have port mem_done, input, 1, the controller completion.
REQ-019 The block SHALL have ports resp_valid (output, 1), resp_data (output, 32), resp_tag (output, TAG_W) and resp_exc (output, 1) forming the result.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP, and all outputs SHALL be registered.
REQ-021 req_ready SHALL be 1 only in IDLE with flush=0.
REQ-022 Accept (IDLE, req_valid & req_ready at an edge) SHALL latch addr = req_base + req_offset mod 2^32 plus funct3, store, wdata and tag, and go to ISSUE.
REQ-023 In ISSUE and WAIT, exactly one of mem_read or mem_write SHALL be 1 and mem_addr, mem_len and mem_signed SHALL be stable.
REQ-024 mem_len SHALL be 0/1/3 for funct3[1:0] = 0/1/2, and code 3 SHALL be treated as word.
REQ-025 mem_signed SHALL equal ~funct3[2] for loads and 0 for stores.
REQ-026 mem_w_data SHALL be wdata with unused upper bytes zeroed (SB keeps [7:0]; SH keeps [15:0]).
REQ-027 ISSUE SHALL last exactly one cycle, with mem_done ignored, then go to WAIT.
REQ-028 In WAIT, a cycle with mem_done=1 SHALL deassert mem_read/mem_write, capture mem_r_data (loads) and go to RESP.
REQ-029 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE, giving at least one idle request cycle between transactions.
REQ-030 In RESP, resp_data SHALL be the load data, or 0 for stores; resp_tag SHALL be the latched tag; resp_exc SHALL be 0.
REQ-031 Minimum latency SHALL be accept edge N to resp_valid high in cycle N+3.
REQ-032 flush in ISSUE or WAIT of a load SHALL set a kill flag, the memory transaction SHALL complete normally, and resp_valid SHALL stay 0 in RESP.
REQ-033 Stores SHALL never be killed once accepted.
REQ-034 flush in IDLE or RESP SHALL have no effect except blocking acceptance.
REQ-035 flush together with req_valid in IDLE SHALL result in no accept.

Reset
REQ-036 rst=0 SHALL immediately force IDLE, clear the kill flag, and drive all outputs to 0 (mem_read, mem_write, mem_addr, mem_len, mem_signed, mem_w_data, resp_*), with req_ready=0 while rst=0.
REQ-037 Reset during ISSUE or WAIT SHALL drop the memory request asynchronously and lose the pending response.
REQ-038 After rst deasserts, req_ready SHALL be 1 on the first clock edge.

Configuration
REQ-039 With macro LSU_MISALIGN_CHECK_EN defined, an accepted half access with addr[0]=1, or an accepted word access with addr[1:0]≠0, SHALL skip ISSUE/WAIT and issue no memory request.
REQ-040 With LSU_MISALIGN_CHECK_EN defined, RESP SHALL follow the next cycle with resp_exc=1 and resp_data=addr; flush SHALL kill this response for loads only.
REQ-041 With LSU_MISALIGN_CHECK_EN undefined, misaligned addresses SHALL pass to the controller unchanged and resp_exc SHALL be constant 0.

Verification
REQ-042 LB with base=0x1000, offset=0xFFFFFFFF, tag=7, mem_done at WAIT cycle 1 with mem_r_data=0xFFFFFF80 -> mem_addr=0xFFF, mem_len=0, mem_signed=1; resp_valid at N+3 with resp_data=0xFFFFFF80, resp_tag=7.
REQ-043 SH with wdata=0xDEADBEEF at addr 0x2002 -> mem_write=1, mem_len=1, mem_w_data=0x0000BEEF until mem_done; resp_valid=1, resp_data=0.
REQ-044 LW with flush pulsed in WAIT and mem_done three cycles later -> mem_read held until mem_done; no resp_valid; req_ready=1 after RESP.
REQ-045 rst=0 mid-WAIT of a LW -> mem_read=0 without a clock edge; after release, LBU 0x10 accepted and completes normally.
REQ-046 With LSU_MISALIGN_CHECK_EN defined, LW at 0x1002 -> mem_read never asserted; resp_exc=1 and resp_data=0x1002 at N+2; without the macro -> mem_read=1 and mem_addr=0x1002.
REQ-047 A base+offset wrap case (0xFFFFFFFE + 4) -> mem_addr=0x00000002.
